// File: rtl/result_row_packer.sv
// Captures 16-sample result bursts into a ping-pong 4x4 buffer and drains each frame as packed rows.
// Optional PACKER_ROWSUM_EN adds a registered signed per-row sum output (out_rowsum).
module result_row_packer #(
    parameter int unsigned W = 7,
    parameter int unsigned N = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [W-1:0]            in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N*W-1:0]          out_row,
    output logic [$clog2(N)-1:0]    out_row_idx,
    output logic                    out_last,
    output logic                    err_len,
    output logic                    err_ovf
`ifdef PACKER_ROWSUM_EN
    ,
    output logic signed [W+$clog2(N)-1:0] out_rowsum
`endif
);

    localparam int unsigned D  = N * N;
    localparam int unsigned RW = $clog2(N);
    localparam int unsigned AW = $clog2(D);
    localparam int unsigned CW = $clog2(D + 2);
    localparam int unsigned SW = W + RW;

    typedef enum logic [1:0] {CapArm, CapIdle, CapColl, CapDrop} cap_e;
    typedef enum logic [0:0] {DrIdle, DrOut} dr_e;

    cap_e          cap_q;
    dr_e           dr_q;
    logic [CW-1:0] cnt_q;
    logic          wb_q, rb_q;
    logic [1:0]    full_q, full_d;
    logic [W-1:0]  mem_q [2][D];

    logic          wr_en, commit, drain_hs, drain_clr, ld_en, ld_bank;
    logic [AW-1:0] wr_addr;
    logic [RW-1:0] ld_idx;

    // Row r of a bank occupies addresses {r, c} since N is a power of two.
    function automatic logic [N*W-1:0] pack_row(input logic b, input logic [RW-1:0] r);
        logic [N*W-1:0] row;
        row = '0;
        for (int c = 0; c < N; c++) begin
            row[c*W +: W] = mem_q[b][{r, RW'(c)}];
        end
        return row;
    endfunction

`ifdef PACKER_ROWSUM_EN
    function automatic logic signed [SW-1:0] sum_row(input logic b, input logic [RW-1:0] r);
        logic signed [SW-1:0] s;
        logic signed [W-1:0]  e;
        s = '0;
        for (int c = 0; c < N; c++) begin
            e = $signed(mem_q[b][{r, RW'(c)}]);
            s = s + SW'(e);
        end
        return s;
    endfunction
`endif

    always_comb begin
        wr_en   = in_valid && ((cap_q == CapIdle && !full_q[wb_q]) ||
                               (cap_q == CapColl && cnt_q < CW'(D)));
        wr_addr = (cap_q == CapIdle) ? '0 : cnt_q[AW-1:0];
        commit  = (cap_q == CapColl) && !in_valid && (cnt_q == CW'(D));
    end

    always_comb begin
        drain_hs  = out_valid && out_ready;
        drain_clr = drain_hs && out_last;
        full_d    = full_q;
        if (commit) full_d[wb_q] = 1'b1;
        if (drain_clr) full_d[rb_q] = 1'b0;
        // Drain decisions see this cycle's commit so a fresh frame shows up one cycle later.
        ld_bank = drain_clr ? ~rb_q : rb_q;
        ld_idx  = (dr_q == DrOut && !drain_clr) ? out_row_idx + RW'(1) : '0;
        ld_en   = (dr_q == DrIdle && full_d[rb_q]) ||
                  (drain_hs && (!out_last || full_d[~rb_q]));
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wb_q][wr_addr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) full_q <= '0;
        else     full_q <= full_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q   <= CapArm;
            cnt_q   <= '0;
            wb_q    <= 1'b0;
            err_len <= 1'b0;
            err_ovf <= 1'b0;
        end else begin
            err_len <= 1'b0;
            err_ovf <= 1'b0;
            unique case (cap_q)
                CapArm: if (!in_valid) cap_q <= CapIdle;
                CapIdle: begin
                    if (in_valid) begin
                        if (!full_q[wb_q]) begin
                            cap_q <= CapColl;
                            cnt_q <= CW'(1);
                        end else begin
                            cap_q <= CapDrop;
                        end
                    end
                end
                CapColl: begin
                    if (in_valid) begin
                        if (cnt_q != CW'(D + 1)) cnt_q <= cnt_q + CW'(1);
                    end else begin
                        if (cnt_q == CW'(D)) wb_q <= ~wb_q;
                        else                 err_len <= 1'b1;
                        cnt_q <= '0;
                        cap_q <= CapIdle;
                    end
                end
                CapDrop: begin
                    if (!in_valid) begin
                        err_ovf <= 1'b1;
                        cap_q   <= CapIdle;
                    end
                end
                default: cap_q <= CapArm;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dr_q        <= DrIdle;
            rb_q        <= 1'b0;
            out_valid   <= 1'b0;
            out_row     <= '0;
            out_row_idx <= '0;
            out_last    <= 1'b0;
`ifdef PACKER_ROWSUM_EN
            out_rowsum  <= '0;
`endif
        end else begin
            if (drain_clr) rb_q <= ~rb_q;
            if (ld_en) begin
                dr_q        <= DrOut;
                out_valid   <= 1'b1;
                out_row     <= pack_row(ld_bank, ld_idx);
                out_row_idx <= ld_idx;
                out_last    <= (ld_idx == RW'(N - 1));
`ifdef PACKER_ROWSUM_EN
                out_rowsum  <= sum_row(ld_bank, ld_idx);
`endif
            end else if (drain_hs) begin
                dr_q      <= DrIdle;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule
